level_stop_ctrl: RTL

Controller for the 4-bit level / 16-bit thermometer bar datapath. It runs a bouncing level counter (0..15..0) at a prescaled step rate. A stop press freezes the current level and issues a one-cycle capture enable with the captured value to the downstream level register. It drives the bar output with either the running level or the captured result, and holds the result for a fixed time before returning to idle.

---
 rtl/level_stop_ctrl_pkg.sv | 10 +
 rtl/tick_prescaler.sv | 20 ++
 rtl/level_stop_ctrl.sv | 109 ++++++++++
 3 files changed

// File: rtl/level_stop_ctrl_pkg.sv
// level_stop_ctrl_pkg: shared state encoding, widths and thermometer helper
package level_stop_ctrl_pkg;
  typedef enum logic [1:0] {IDLE = 2'd0, RUN = 2'd1, HOLD = 2'd2} state_t;
  localparam int LEVEL_W = 4;
  localparam int BAR_W = 16;
  localparam logic [LEVEL_W-1:0] LEVEL_MAX = 4'd15;
  function automatic logic [BAR_W-1:0] therm(input logic [LEVEL_W-1:0] n);
    return BAR_W'((32'd2 << n) - 32'd1);
  endfunction
endpackage

// File: rtl/tick_prescaler.sv
// tick_prescaler: wrapping 0..TICK_DIV-1 counter, tick at terminal count, sync clear
module tick_prescaler #(
  parameter int TICK_DIV = 4
) (
  input  logic clk,
  input  logic reset,
  input  logic clr,
  output logic tick
);
  localparam int CW = $clog2(TICK_DIV);
  logic [CW-1:0] cnt_q, cnt_d;
  always_comb begin
    tick = cnt_q == CW'(TICK_DIV - 1);
    cnt_d = (clr || tick) ? '0 : cnt_q + 1'b1;
  end
  always_ff @(posedge clk or posedge reset) begin
    if (reset) cnt_q <= '0;
    else cnt_q <= cnt_d;
  end
endmodule

// File: rtl/level_stop_ctrl.sv
// level_stop_ctrl: bouncing level counter with stop capture, timed result hold and bar drive
module level_stop_ctrl
  import level_stop_ctrl_pkg::*;
#(
  parameter int TICK_DIV   = 4,
  parameter int HOLD_TICKS = 8
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               start,
  input  logic               stop,
  output logic [LEVEL_W-1:0] level,
  output logic               dir,
  output logic               cap_en,
  output logic [LEVEL_W-1:0] cap_level,
  output logic [BAR_W-1:0]   bar,
  output logic               busy
);
  localparam int HW = $clog2(HOLD_TICKS + 1);
  state_t state_q, state_d;
  logic [LEVEL_W-1:0] level_q, level_d, cap_level_q, cap_level_d;
  logic [BAR_W-1:0] bar_q, bar_d;
  logic [HW-1:0] hold_q, hold_d;
  logic dir_q, dir_d, cap_en_q, cap_en_d, valid_q, valid_d, busy_q, busy_d;
  logic stop_q, stop_edge, tick, clr;
  tick_prescaler #(.TICK_DIV(TICK_DIV)) u_pre (
    .clk  (clk),
    .reset(reset),
    .clr  (clr),
    .tick (tick)
  );
  always_comb begin
    stop_edge = stop & ~stop_q;
    state_d = state_q;
    level_d = level_q;
    dir_d = dir_q;
    cap_en_d = 1'b0;
    cap_level_d = cap_level_q;
    valid_d = valid_q;
    hold_d = hold_q;
    clr = 1'b0;
    case (state_q)
      IDLE: begin
        clr = 1'b1;
        if (start) begin
          state_d = RUN;
          level_d = '0;
          dir_d = 1'b1;
        end
      end
      RUN: begin
        // a stop edge beats a coinciding tick: the pre-step level is captured
        if (stop_edge) begin
          state_d = HOLD;
          cap_level_d = level_q;
          cap_en_d = 1'b1;
          valid_d = 1'b1;
          hold_d = '0;
          clr = 1'b1;
        end else if (tick) begin
          dir_d = (dir_q && level_q == LEVEL_MAX) ? 1'b0 : (!dir_q && level_q == '0) ? 1'b1 : dir_q;
          level_d = dir_d ? level_q + 1'b1 : level_q - 1'b1;
        end
      end
      HOLD: begin
        if (tick) begin
          if (hold_q == HW'(HOLD_TICKS - 1)) begin
            state_d = IDLE;
            hold_d = '0;
          end else hold_d = hold_q + 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
    busy_d = state_d != IDLE;
    bar_d = state_d == RUN ? therm(level_d) : (state_d == HOLD || valid_d) ? therm(cap_level_d) : '0;
  end
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      level_q <= '0;
      dir_q <= 1'b1;
      stop_q <= 1'b0;
      cap_en_q <= 1'b0;
      cap_level_q <= '0;
      valid_q <= 1'b0;
      bar_q <= '0;
      busy_q <= 1'b0;
      hold_q <= '0;
    end else begin
      state_q <= state_d;
      level_q <= level_d;
      dir_q <= dir_d;
      stop_q <= stop;
      cap_en_q <= cap_en_d;
      cap_level_q <= cap_level_d;
      valid_q <= valid_d;
      bar_q <= bar_d;
      busy_q <= busy_d;
      hold_q <= hold_d;
    end
  end
  assign level = level_q;
  assign dir = dir_q;
  assign cap_en = cap_en_q;
  assign cap_level = cap_level_q;
  assign bar = bar_q;
  assign busy = busy_q;
endmodule
